// File: rtl/h14tx_pkg.sv
// Shared types for the HDMI 1.4 transmitter data-island path: pixel period codes,
// whole-packet layout and the BCH single-bit update used by the serial ECC.
package h14tx_pkg;

  typedef enum logic [2:0] {
    Control            = 3'd0,
    VideoPreamble      = 3'd1,
    VideoGuard         = 3'd2,
    VideoActive        = 3'd3,
    DataIslandPreamble = 3'd4,
    DataIslandGuard    = 3'd5,
    DataIslandActive   = 3'd6
  } period_t;

  typedef struct packed {
    logic [23:0]  header;
    logic [223:0] body;
  } packet_t;

  localparam packet_t NullPacket = {248{1'b0}};
  localparam logic [7:0] EccPolyDefault = 8'h83;

  // Right-shift BCH step: the bit leaving e[0] decides whether the mask is folded back in.
  function automatic logic [7:0] eccStep(input logic [7:0] e, input logic b, input logic [7:0] poly);
    logic fb;
    fb = b ^ e[0];
    return {1'b0, e[7:1]} ^ (fb ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/h14tx_packet_serializer_if.sv
// Packet hand-off from the infoframe/audio sources into the data-island serializer.
interface h14tx_packet_serializer_if;
  logic         pkt_valid;
  logic         pkt_ready;
  logic [23:0]  pkt_header;
  logic [223:0] pkt_body;

  modport master (output pkt_valid, output pkt_header, output pkt_body, input pkt_ready);
  modport slave  (input pkt_valid, input pkt_header, input pkt_body, output pkt_ready);
endinterface

// File: rtl/h14tx_bch_ecc.sv
// Serial BCH parity accumulator: folds BitsPerClk bits per clock, lowest din bit first.
module h14tx_bch_ecc
  import h14tx_pkg::*;
#(
  parameter int         BitsPerClk = 1,
  parameter logic [7:0] Poly       = EccPolyDefault
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  en,
  input  logic [BitsPerClk-1:0] din,
  output logic [7:0]            ecc
);

  logic [7:0] eccBase;
  logic [7:0] eccNext;

  // Clear and the first bits of a new packet land in the same clock.
  always_comb begin
    eccBase = clear ? 8'h00 : ecc;
    eccNext = eccBase;
    if (en) begin
      for (int i = 0; i < BitsPerClk; i++) begin
        eccNext = eccStep(eccNext, din[i], Poly);
      end
    end else begin
      eccNext = eccBase;
    end
  end

  // Parity register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ecc <= 8'h00;
    end else begin
      ecc <= eccNext;
    end
  end

endmodule

// File: rtl/h14tx_packet_serializer.sv
// Data-island serializer: buffers whole packets and emits one per 32-clock slot as
// per-channel TERC4 nibbles (header+BCH on ch0[2], four subpackets+BCH on ch1/ch2).
module h14tx_packet_serializer
  import h14tx_pkg::*;
#(
  parameter int         Depth   = 2,
  parameter logic [7:0] EccPoly = EccPolyDefault
) (
  input  logic                     clk,
  input  logic                     rst,
  input  period_t                  timings,
  input  logic                     hsync,
  input  logic                     vsync,
  h14tx_packet_serializer_if.slave pkt,
  output period_t                  timings_o,
  output logic [3:0]               ch0,
  output logic [3:0]               ch1,
  output logic [3:0]               ch2
);

  localparam int PtrW = (Depth > 2) ? 2 : 1;
  localparam logic [2:0] DepthC = 3'(Depth);

  packet_t          mem [Depth];
  logic [PtrW-1:0]  wrPtr, rdPtr;
  logic [2:0]       count, countNext;
  logic             readyR, prevActive;
  logic [4:0]       slotCnt;
  logic [23:0]      hdrSr;
  logic [3:0][55:0] sbSr;
  logic             isActive, slotStart, push, pop;
  packet_t          headPkt;
  logic             hdrBit;
  logic [3:0][1:0]  sbBits;
  logic [7:0]       hdrEcc;
  logic [3:0][7:0]  sbEcc;
  logic [3:0]       ch0Next, ch1Next, ch2Next;

  function automatic logic [PtrW-1:0] ptrInc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? {PtrW{1'b0}} : p + PtrW'(1);
  endfunction

  assign isActive      = (timings == DataIslandActive);
  assign slotStart     = isActive && (slotCnt == 5'd0);
  assign push          = pkt.pkt_valid && readyR;
  assign pop           = slotStart && (count != 3'd0);
  assign headPkt       = (count != 3'd0) ? mem[rdPtr] : NullPacket;
  assign pkt.pkt_ready = readyR;

  // FIFO occupancy after this clock's push/pop.
  always_comb begin
    case ({push, pop})
      2'b10:   countNext = count + 3'd1;
      2'b01:   countNext = count - 3'd1;
      default: countNext = count;
    endcase
  end

  // At slot start the bits come straight from the popped packet, afterwards from the shifters.
  always_comb begin
    hdrBit = hdrSr[0];
    for (int k = 0; k < 4; k++) begin
      sbBits[k] = sbSr[k][1:0];
    end
    if (slotStart) begin
      hdrBit = headPkt.header[0];
      for (int k = 0; k < 4; k++) begin
        sbBits[k] = headPkt.body[56*k +: 2];
      end
    end else begin
      hdrBit = hdrSr[0];
    end
  end

  // Next output nibbles: data/ECC muxing inside the island, syncs only elsewhere.
  always_comb begin
    ch0Next = {2'b00, vsync, hsync};
    ch1Next = 4'h0;
    ch2Next = 4'h0;
    if (isActive) begin
      ch0Next[3] = prevActive;
      ch0Next[2] = (slotCnt < 5'd24) ? hdrBit : hdrEcc[slotCnt[2:0]];
      for (int k = 0; k < 4; k++) begin
        if (slotCnt < 5'd28) begin
          ch1Next[k] = sbBits[k][0];
          ch2Next[k] = sbBits[k][1];
        end else begin
          ch1Next[k] = sbEcc[k][{slotCnt[1:0], 1'b0}];
          ch2Next[k] = sbEcc[k][{slotCnt[1:0], 1'b1}];
        end
      end
    end else begin
      ch0Next = {2'b00, vsync, hsync};
    end
  end

  // Packet storage; contents are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr].header <= pkt.pkt_header;
      mem[wrPtr].body   <= pkt.pkt_body;
    end
  end

  // FIFO control, slot sequencing, shifters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= 3'd0;
      readyR     <= 1'b1;
      wrPtr      <= {PtrW{1'b0}};
      rdPtr      <= {PtrW{1'b0}};
      prevActive <= 1'b0;
      slotCnt    <= 5'd0;
      hdrSr      <= 24'h000000;
      sbSr       <= {224{1'b0}};
      timings_o  <= Control;
      ch0        <= 4'h0;
      ch1        <= 4'h0;
      ch2        <= 4'h0;
    end else begin
      count      <= countNext;
      readyR     <= (countNext != DepthC);
      if (push) wrPtr <= ptrInc(wrPtr);
      if (pop)  rdPtr <= ptrInc(rdPtr);
      prevActive <= isActive;
      slotCnt    <= isActive ? slotCnt + 5'd1 : 5'd0;
      if (isActive) begin
        hdrSr <= slotStart ? {1'b0, headPkt.header[23:1]} : {1'b0, hdrSr[23:1]};
        for (int k = 0; k < 4; k++) begin
          sbSr[k] <= slotStart ? {2'b00, headPkt.body[56*k+2 +: 54]} : {2'b00, sbSr[k][55:2]};
        end
      end
      timings_o <= timings;
      ch0       <= ch0Next;
      ch1       <= ch1Next;
      ch2       <= ch2Next;
    end
  end

  h14tx_bch_ecc #(.BitsPerClk(1), .Poly(EccPoly)) uHdrEcc (
    .clk(clk), .rst(rst), .clear(slotStart),
    .en(isActive && (slotCnt < 5'd24)), .din(hdrBit), .ecc(hdrEcc)
  );

  for (genvar k = 0; k < 4; k++) begin : gSub
    h14tx_bch_ecc #(.BitsPerClk(2), .Poly(EccPoly)) uSubEcc (
      .clk(clk), .rst(rst), .clear(slotStart),
      .en(isActive && (slotCnt < 5'd28)), .din(sbBits[k]), .ecc(sbEcc[k])
    );
  end

endmodule

// File: tb/tb_h14tx_packet_serializer.sv
// Bench for the data-island serializer: non-island vectors from a table, island slots
// checked against a bit-serial packet/BCH model through an expectation queue.
module tb_h14tx_packet_serializer;
  import h14tx_pkg::*;

  localparam int DEPTH = 2;

  typedef struct {
    period_t    tim;
    logic [3:0] c0, c1, c2;
  } exp_t;

  typedef struct {
    period_t    tim;
    logic       hs, vs;
    logic [3:0] expCh0;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  period_t    timings, timings_o;
  logic       hsync, vsync;
  logic [3:0] ch0, ch1, ch2;

  h14tx_packet_serializer_if ifc();

  h14tx_packet_serializer #(.Depth(DEPTH), .EccPoly(8'h83)) dut (
    .clk(clk), .rst(rst), .timings(timings), .hsync(hsync), .vsync(vsync),
    .pkt(ifc), .timings_o(timings_o), .ch0(ch0), .ch1(ch1), .ch2(ch2)
  );

  always #5 clk = ~clk;

  int      nVec = 0;
  int      nMis = 0;
  exp_t    sb[$];
  packet_t mFifo[$];
  packet_t mCur;
  int      mCnt = 0;
  logic    mPrev = 1'b0;
  logic [7:0] mHecc;
  logic [7:0] mSecc [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] eccRef(input logic [55:0] bits, input int n);
    logic [7:0] e;
    logic fb;
    e = 8'h00;
    for (int i = 0; i < n; i++) begin
      fb = bits[i] ^ e[0];
      e = {1'b0, e[7:1]} ^ (fb ? 8'h83 : 8'h00);
    end
    return e;
  endfunction

  function automatic packet_t rpkt();
    packet_t p;
    p.header = 24'($urandom);
    for (int i = 0; i < 7; i++) p.body[32*i +: 32] = $urandom;
    return p;
  endfunction

  // One clock: predict outputs from the model, queue them, then compare after the edge.
  task automatic cycle();
    exp_t e;
    logic rdy, hb;
    logic [55:0] s;
    rdy = (mFifo.size() < DEPTH);
    check("pkt_ready", 32'(ifc.pkt_ready), 32'(rdy));
    e.tim = timings;
    e.c0 = {2'b00, vsync, hsync};
    e.c1 = 4'h0;
    e.c2 = 4'h0;
    if (timings == DataIslandActive) begin
      if (mCnt == 0) begin
        if (mFifo.size() > 0) mCur = mFifo.pop_front();
        else mCur = NullPacket;
        mHecc = eccRef({32'h0, mCur.header}, 24);
        for (int k = 0; k < 4; k++) mSecc[k] = eccRef(mCur.body[56*k +: 56], 56);
      end
      hb = (mCnt < 24) ? mCur.header[mCnt] : mHecc[mCnt-24];
      e.c0 = {mPrev, hb, vsync, hsync};
      for (int k = 0; k < 4; k++) begin
        s = mCur.body[56*k +: 56];
        if (mCnt < 28) begin
          e.c1[k] = s[2*mCnt];
          e.c2[k] = s[2*mCnt+1];
        end else begin
          e.c1[k] = mSecc[k][2*(mCnt-28)];
          e.c2[k] = mSecc[k][2*(mCnt-28)+1];
        end
      end
      mCnt = (mCnt + 1) % 32;
      mPrev = 1'b1;
    end else begin
      mCnt = 0;
      mPrev = 1'b0;
    end
    if (ifc.pkt_valid && rdy) mFifo.push_back(packet_t'{ifc.pkt_header, ifc.pkt_body});
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("timings_o", 32'(timings_o), 32'(e.tim));
    check("ch0", 32'(ch0), 32'(e.c0));
    check("ch1", 32'(ch1), 32'(e.c1));
    check("ch2", 32'(ch2), 32'(e.c2));
  endtask

  task automatic run(input period_t t, input int n, input logic rndSync);
    timings = t;
    for (int i = 0; i < n; i++) begin
      if (rndSync) begin
        hsync = 1'($urandom);
        vsync = 1'($urandom);
      end
      cycle();
    end
  endtask

  task automatic offer(input packet_t p);
    ifc.pkt_valid  = 1'b1;
    ifc.pkt_header = p.header;
    ifc.pkt_body   = p.body;
  endtask

  vec_t       vt [6];
  logic [7:0] cap;
  packet_t    p3;

  initial begin
    rst = 1'b1;
    timings = Control;
    hsync = 1'b0;
    vsync = 1'b0;
    ifc.pkt_valid = 1'b0;
    ifc.pkt_header = 24'h0;
    ifc.pkt_body = {224{1'b0}};
    vt[0] = '{Control,            1'b0, 1'b0, 4'b0000};
    vt[1] = '{Control,            1'b1, 1'b0, 4'b0001};
    vt[2] = '{VideoPreamble,      1'b0, 1'b1, 4'b0010};
    vt[3] = '{DataIslandGuard,    1'b1, 1'b1, 4'b0011};
    vt[4] = '{DataIslandPreamble, 1'b1, 1'b0, 4'b0001};
    vt[5] = '{VideoActive,        1'b0, 1'b1, 4'b0010};

    // Reset held, then released in Control.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ifc.pkt_ready), 32'd1);
    check("rst_ch1", 32'(ch1), 32'd0);
    check("rst_ch2", 32'(ch2), 32'd0);
    check("rst_timings_o", 32'(timings_o), 32'(Control));
    rst = 1'b0;
    run(Control, 2, 1'b0);

    // Non-island periods: only syncs on ch0.
    for (int i = 0; i < 6; i++) begin
      timings = vt[i].tim;
      hsync = vt[i].hs;
      vsync = vt[i].vs;
      @(posedge clk);
      #1;
      check("vec_timings_o", 32'(timings_o), 32'(vt[i].tim));
      check("vec_ch0", 32'(ch0), 32'(vt[i].expCh0));
      check("vec_ch1", 32'(ch1), 32'd0);
      check("vec_ch2", 32'(ch2), 32'd0);
    end
    mCnt = 0;
    mPrev = 1'b0;
    hsync = 1'b0;
    vsync = 1'b0;

    // Empty buffer: null packet for a whole slot.
    run(DataIslandActive, 32, 1'b0);
    run(Control, 2, 1'b0);

    // Known header, LSB first, with ECC tail.
    p3.header = 24'h0D0282;
    p3.body = {224{1'b0}};
    p3.body[7:0] = 8'h01;
    offer(p3);
    run(Control, 1, 1'b0);
    ifc.pkt_valid = 1'b0;
    run(Control, 1, 1'b0);
    timings = DataIslandActive;
    for (int i = 0; i < 32; i++) begin
      cycle();
      if (i < 8) cap[i] = ch0[2];
    end
    check("hdr_byte0_serial", 32'(cap), 32'h82);
    run(Control, 2, 1'b1);

    // Fill to full with valid held, slot start frees one entry.
    offer(rpkt());
    run(Control, 1, 1'b0);
    offer(rpkt());
    run(Control, 1, 1'b0);
    offer(rpkt());
    run(Control, 2, 1'b0);
    check("full_ready", 32'(ifc.pkt_ready), 32'd0);
    run(DataIslandActive, 1, 1'b1);
    check("ready_after_pop", 32'(ifc.pkt_ready), 32'd1);
    run(DataIslandActive, 1, 1'b1);
    ifc.pkt_valid = 1'b0;
    run(DataIslandActive, 62, 1'b1);
    run(Control, 3, 1'b1);

    // One entry left; push coincides with the slot-start pop.
    offer(rpkt());
    run(DataIslandActive, 1, 1'b1);
    ifc.pkt_valid = 1'b0;
    run(DataIslandActive, 31, 1'b1);
    run(Control, 2, 1'b1);

    // One packet queued over a two-slot island: packet then null, wrap keeps first_n high.
    run(DataIslandActive, 64, 1'b1);
    run(Control, 2, 1'b1);

    // Reset mid-island at c=10 with the buffer full.
    offer(rpkt());
    run(Control, 1, 1'b0);
    offer(rpkt());
    run(Control, 1, 1'b0);
    ifc.pkt_valid = 1'b0;
    run(DataIslandActive, 1, 1'b1);
    offer(rpkt());
    run(DataIslandActive, 1, 1'b1);
    ifc.pkt_valid = 1'b0;
    run(DataIslandActive, 8, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_ch0", 32'(ch0), 32'd0);
    check("midrst_ch1", 32'(ch1), 32'd0);
    check("midrst_ch2", 32'(ch2), 32'd0);
    check("midrst_timings_o", 32'(timings_o), 32'(Control));
    check("midrst_ready", 32'(ifc.pkt_ready), 32'd1);
    mFifo.delete();
    mCnt = 0;
    mPrev = 1'b0;
    timings = Control;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run(Control, 2, 1'b0);
    timings = DataIslandActive;
    for (int i = 0; i < 32; i++) begin
      cycle();
      if (i == 0) check("post_rst_null_hdr", 32'(ch0[2]), 32'd0);
    end
    run(Control, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
